// File: rtl/option_rom_access_ctrl_pkg.sv
// Shared constants and FSM encoding for the Option ROM access controller.
// Signature bytes, blank-EPROM response and sequencer states.
package option_rom_access_ctrl_pkg;

    localparam logic [7:0] ROM_SIG0   = 8'h55;
    localparam logic [7:0] ROM_SIG1   = 8'hAA;
    localparam logic [7:0] BLANK_BYTE = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISA_RD,
        ST_ISA_CAP,
        ST_ISA_HOLD,
        ST_UPD_WAIT,
        ST_UPD_WR,
        ST_SCAN
    } rom_state_e;

endpackage

// File: rtl/option_rom_access_ctrl_if.sv
// Image-update write stream from the soft CPU.
// Master is the CPU side, slave is the ROM access controller.
interface option_rom_access_ctrl_if #(
    parameter int ADDR_W = 15
) ();

    logic              upd_start;
    logic              upd_valid;
    logic              upd_ready;
    logic [ADDR_W-1:0] upd_addr;
    logic [7:0]        upd_data;
    logic              upd_last;

    modport master (
        output upd_start, upd_valid, upd_addr, upd_data, upd_last,
        input  upd_ready
    );

    modport slave (
        input  upd_start, upd_valid, upd_addr, upd_data, upd_last,
        output upd_ready
    );

endinterface

// File: rtl/option_rom_access_ctrl_rom_csum_scanner.sv
// Checksum scanner: address counter, mod-256 byte sum and signature check.
// Reads issue one per clock; data returns two clocks after issue.
module option_rom_access_ctrl_rom_csum_scanner
    import option_rom_access_ctrl_pkg::*;
#(
    parameter int ADDR_W    = 15,
    parameter int ROM_BYTES = 16384
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              issue,
    input  logic [7:0]        rdata,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              all_issued,
    output logic              idle,
    output logic [7:0]        sum,
    output logic              sig_ok
);

    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(ROM_BYTES);
    localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

    logic [ADDR_W:0] cnt;
    logic            p1;
    logic            p2;
    logic [1:0]      tag1;
    logic [1:0]      tag2;
    logic            sig0;
    logic            sig1;

    // tag: 0 = byte 0, 1 = byte 1, 2 = any other byte
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt  <= '0;
            p1   <= 1'b0;
            p2   <= 1'b0;
            tag1 <= 2'd2;
            tag2 <= 2'd2;
            sum  <= 8'h00;
            sig0 <= 1'b0;
            sig1 <= 1'b0;
        end else if (clear) begin
            cnt  <= '0;
            p1   <= 1'b0;
            p2   <= 1'b0;
            tag1 <= 2'd2;
            tag2 <= 2'd2;
            sum  <= 8'h00;
            sig0 <= 1'b0;
            sig1 <= 1'b0;
        end else begin
            p1   <= issue;
            p2   <= p1;
            tag2 <= tag1;
            if (issue) begin
                cnt <= cnt + ONE;
                if (cnt == '0)
                    tag1 <= 2'd0;
                else if (cnt == ONE)
                    tag1 <= 2'd1;
                else
                    tag1 <= 2'd2;
            end
            if (p2) begin
                sum <= sum + rdata;
                if (tag2 == 2'd0)
                    sig0 <= (rdata == ROM_SIG0);
                if (tag2 == 2'd1)
                    sig1 <= (rdata == ROM_SIG1);
            end
        end
    end

    assign rd_addr    = cnt[ADDR_W-1:0];
    assign all_issued = (cnt == LIMIT);
    assign idle       = !p1 && !p2;
    assign sig_ok     = sig0 && sig1;

endmodule

// File: rtl/option_rom_access_ctrl.sv
// Option ROM BRAM sequencer: ISA reads, soft-CPU image updates, checksum scan.
// ISA always wins the single BRAM port; ROM is served only once the image is trusted.
module option_rom_access_ctrl
    import option_rom_access_ctrl_pkg::*;
#(
    parameter int ROM_ADDR_W    = 15,
    parameter int ROM_BYTES     = 16384,
    parameter int SYNC_STAGES   = 2,
    parameter bit LIVE_AT_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  isa_sel,
    input  logic [ROM_ADDR_W-1:0] isa_addr,
    output logic [7:0]            isa_rdata,
    output logic                  isa_rdata_vld,
    output logic                  isa_chrdy,
    option_rom_access_ctrl_if.slave upd,
    output logic                  upd_busy,
    output logic                  csum_done,
    output logic                  csum_ok,
    output logic [7:0]            csum_sum,
    output logic                  rom_live,
    output logic                  bram_en,
    output logic                  bram_we,
    output logic [ROM_ADDR_W-1:0] bram_addr,
    output logic [7:0]            bram_wdata,
    input  logic [7:0]            bram_rdata
);

    logic [SYNC_STAGES-1:0] sel_q;
    logic                   sel_s1;
    logic                   sel_s;

    rom_state_e state_q, state_n;
    rom_state_e ret_q, ret_n;

    logic                  vld_n;
    logic [7:0]            rdata_n;
    logic                  chrdy_n;
    logic                  busy_n;
    logic                  done_n;
    logic                  ok_n;
    logic [7:0]            sum_n;
    logic                  live_n;
    logic                  en_n;
    logic                  we_n;
    logic [ROM_ADDR_W-1:0] addr_n;
    logic [7:0]            wdata_n;
    logic                  last_q;
    logic                  last_n;
    logic                  isa_go;
    logic                  upd_rdy;

    logic                  scan_clear;
    logic                  scan_issue;
    logic [ROM_ADDR_W-1:0] scan_addr;
    logic                  scan_all;
    logic                  scan_idle;
    logic [7:0]            scan_sum;
    logic                  scan_sig;

    assign sel_s1 = sel_q[0];
    assign sel_s  = sel_q[SYNC_STAGES-1];

    // Hold off the CPU as soon as a select is seen, before it is fully synced
    assign upd_rdy       = (state_q == ST_UPD_WAIT) && !sel_s && !sel_s1;
    assign upd.upd_ready = upd_rdy;

    option_rom_access_ctrl_rom_csum_scanner #(
        .ADDR_W    (ROM_ADDR_W),
        .ROM_BYTES (ROM_BYTES)
    ) u_scan (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (scan_clear),
        .issue      (scan_issue),
        .rdata      (bram_rdata),
        .rd_addr    (scan_addr),
        .all_issued (scan_all),
        .idle       (scan_idle),
        .sum        (scan_sum),
        .sig_ok     (scan_sig)
    );

    always_comb begin
        state_n    = state_q;
        ret_n      = ret_q;
        vld_n      = isa_rdata_vld;
        rdata_n    = isa_rdata;
        busy_n     = upd_busy;
        done_n     = 1'b0;
        ok_n       = csum_ok;
        sum_n      = csum_sum;
        live_n     = rom_live;
        en_n       = 1'b0;
        we_n       = 1'b0;
        addr_n     = bram_addr;
        wdata_n    = bram_wdata;
        last_n     = last_q;
        isa_go     = 1'b0;
        scan_clear = 1'b0;
        scan_issue = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (sel_s) begin
                    isa_go = 1'b1;
                    ret_n  = ST_IDLE;
                end else if (upd.upd_start) begin
                    state_n = ST_UPD_WAIT;
                    live_n  = 1'b0;
                    ok_n    = 1'b0;
                    busy_n  = 1'b1;
                end
            end
            ST_ISA_RD: state_n = ST_ISA_CAP;
            ST_ISA_CAP: begin
                rdata_n = rom_live ? bram_rdata : BLANK_BYTE;
                vld_n   = 1'b1;
                state_n = ST_ISA_HOLD;
            end
            ST_ISA_HOLD: begin
                if (!sel_s) begin
                    vld_n   = 1'b0;
                    state_n = ret_q;
                end
            end
            ST_UPD_WAIT: begin
                if (sel_s) begin
                    isa_go = 1'b1;
                    ret_n  = ST_UPD_WAIT;
                end else if (upd.upd_valid && upd_rdy) begin
                    en_n    = 1'b1;
                    we_n    = 1'b1;
                    addr_n  = upd.upd_addr;
                    wdata_n = upd.upd_data;
                    last_n  = upd.upd_last;
                    state_n = ST_UPD_WR;
                end
            end
            ST_UPD_WR: begin
                if (last_q) begin
                    state_n    = ST_SCAN;
                    scan_clear = 1'b1;
                    last_n     = 1'b0;
                end else begin
                    state_n = ST_UPD_WAIT;
                end
            end
            ST_SCAN: begin
                if (sel_s) begin
                    isa_go = 1'b1;
                    ret_n  = ST_SCAN;
                end else if (!scan_all) begin
                    scan_issue = 1'b1;
                    en_n       = 1'b1;
                    addr_n     = scan_addr;
                end else if (scan_idle) begin
                    sum_n   = scan_sum;
                    ok_n    = (scan_sum == 8'h00) && scan_sig;
                    live_n  = (scan_sum == 8'h00) && scan_sig;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        if (isa_go) begin
            state_n = ST_ISA_RD;
            if (rom_live) begin
                en_n   = 1'b1;
                addr_n = isa_addr;
            end
        end

        chrdy_n = !(sel_s1 && !vld_n);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_q         <= '0;
            state_q       <= ST_IDLE;
            ret_q         <= ST_IDLE;
            isa_rdata     <= BLANK_BYTE;
            isa_rdata_vld <= 1'b0;
            isa_chrdy     <= 1'b1;
            upd_busy      <= 1'b0;
            csum_done     <= 1'b0;
            csum_ok       <= LIVE_AT_RESET;
            csum_sum      <= 8'h00;
            rom_live      <= LIVE_AT_RESET;
            bram_en       <= 1'b0;
            bram_we       <= 1'b0;
            bram_addr     <= '0;
            bram_wdata    <= 8'h00;
            last_q        <= 1'b0;
        end else begin
            sel_q         <= {sel_q[SYNC_STAGES-2:0], isa_sel};
            state_q       <= state_n;
            ret_q         <= ret_n;
            isa_rdata     <= rdata_n;
            isa_rdata_vld <= vld_n;
            isa_chrdy     <= chrdy_n;
            upd_busy      <= busy_n;
            csum_done     <= done_n;
            csum_ok       <= ok_n;
            csum_sum      <= sum_n;
            rom_live      <= live_n;
            bram_en       <= en_n;
            bram_we       <= we_n;
            bram_addr     <= addr_n;
            bram_wdata    <= wdata_n;
            last_q        <= last_n;
        end
    end

endmodule

// File: tb/tb_option_rom_access_ctrl.sv
// Scoreboard bench for option_rom_access_ctrl with a behavioural BRAM.
// Stimulus pushes expected ISA bytes and scan results; monitors pop on valid/done.
module tb_option_rom_access_ctrl;

    localparam int AW = 15;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          isa_sel = 1'b0;
    logic [AW-1:0] isa_addr = '0;
    logic [7:0]    isa_rdata;
    logic          isa_rdata_vld;
    logic          isa_chrdy;
    logic          upd_busy;
    logic          csum_done;
    logic          csum_ok;
    logic [7:0]    csum_sum;
    logic          rom_live;
    logic          bram_en;
    logic          bram_we;
    logic [AW-1:0] bram_addr;
    logic [7:0]    bram_wdata;
    logic [7:0]    bram_rdata = 8'h00;

    logic [7:0] mem [0:32767];

    option_rom_access_ctrl_if #(.ADDR_W(AW)) upd_if ();

    option_rom_access_ctrl #(
        .ROM_ADDR_W    (AW),
        .ROM_BYTES     (16384),
        .SYNC_STAGES   (2),
        .LIVE_AT_RESET (1'b1)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .isa_sel       (isa_sel),
        .isa_addr      (isa_addr),
        .isa_rdata     (isa_rdata),
        .isa_rdata_vld (isa_rdata_vld),
        .isa_chrdy     (isa_chrdy),
        .upd           (upd_if),
        .upd_busy      (upd_busy),
        .csum_done     (csum_done),
        .csum_ok       (csum_ok),
        .csum_sum      (csum_sum),
        .rom_live      (rom_live),
        .bram_en       (bram_en),
        .bram_we       (bram_we),
        .bram_addr     (bram_addr),
        .bram_wdata    (bram_wdata),
        .bram_rdata    (bram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bram_en) begin
            if (bram_we)
                mem[bram_addr] <= bram_wdata;
            bram_rdata <= mem[bram_addr];
        end
    end

    int         checks = 0;
    int         errors = 0;
    logic [7:0] isa_q [$];
    logic [9:0] csum_q [$];
    logic [7:0] isa_e;
    logic [9:0] cs_e;
    logic       vld_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ISA read-data monitor
    always @(negedge clk) begin
        if (isa_rdata_vld && !vld_prev) begin
            if (isa_q.size() == 0) begin
                check("isa_unexpected_read", isa_q.size(), 1);
            end else begin
                isa_e = isa_q.pop_front();
                check("isa_rdata", isa_rdata, isa_e);
                check("isa_chrdy_at_vld", isa_chrdy, 1);
            end
        end
        vld_prev = isa_rdata_vld;
    end

    // Checksum result monitor
    always @(negedge clk) begin
        if (csum_done) begin
            if (csum_q.size() == 0) begin
                check("csum_unexpected_done", csum_q.size(), 1);
            end else begin
                cs_e = csum_q.pop_front();
                check("csum_sum", csum_sum, cs_e[9:2]);
                check("csum_ok", csum_ok, cs_e[1]);
                check("rom_live_after_scan", rom_live, cs_e[0]);
                check("busy_at_done", upd_busy, 0);
            end
        end
    end

    task automatic reset_values(input string tag);
        check({tag, "_isa_rdata"}, isa_rdata, 8'hFF);
        check({tag, "_isa_vld"}, isa_rdata_vld, 0);
        check({tag, "_isa_chrdy"}, isa_chrdy, 1);
        check({tag, "_upd_ready"}, upd_if.upd_ready, 0);
        check({tag, "_upd_busy"}, upd_busy, 0);
        check({tag, "_csum_done"}, csum_done, 0);
        check({tag, "_csum_ok"}, csum_ok, 1);
        check({tag, "_csum_sum"}, csum_sum, 0);
        check({tag, "_rom_live"}, rom_live, 1);
        check({tag, "_bram_en_we"}, {bram_en, bram_we}, 0);
        check({tag, "_bram_addr"}, bram_addr, 0);
        check({tag, "_bram_wdata"}, bram_wdata, 0);
    endtask

    task automatic isa_read(input logic [AW-1:0] a, input logic [7:0] exp);
        int n = 0;
        @(negedge clk);
        isa_addr = a;
        isa_sel  = 1'b1;
        isa_q.push_back(exp);
        @(negedge clk);
        @(negedge clk);
        check("isa_chrdy_wait", isa_chrdy, 0);
        while (!isa_rdata_vld && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!isa_rdata_vld)
            check("isa_vld_timeout", isa_rdata_vld, 1);
        isa_sel = 1'b0;
        n = 0;
        while (isa_rdata_vld && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (isa_rdata_vld)
            check("isa_vld_release", isa_rdata_vld, 0);
    endtask

    task automatic start_session();
        @(negedge clk);
        upd_if.upd_start = 1'b1;
        @(negedge clk);
        upd_if.upd_start = 1'b0;
        check("session_busy", upd_busy, 1);
        check("session_live", rom_live, 0);
        check("session_ok", csum_ok, 0);
    endtask

    task automatic beat(input logic [AW-1:0] a, input logic [7:0] d,
                        input logic l);
        int n = 0;
        upd_if.upd_valid = 1'b1;
        upd_if.upd_addr  = a;
        upd_if.upd_data  = d;
        upd_if.upd_last  = l;
        while (!upd_if.upd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!upd_if.upd_ready)
            check("beat_ready_timeout", upd_if.upd_ready, 1);
        @(negedge clk);
        upd_if.upd_valid = 1'b0;
        upd_if.upd_last  = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!csum_done && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (!csum_done)
            check("csum_done_timeout", csum_done, 1);
        @(negedge clk);
    endtask

    logic seen;
    int   wn;

    initial begin
        upd_if.upd_start = 1'b0;
        upd_if.upd_valid = 1'b0;
        upd_if.upd_addr  = '0;
        upd_if.upd_data  = 8'h00;
        upd_if.upd_last  = 1'b0;
        for (int i = 0; i < 32768; i++)
            mem[i] = 8'h00;
        // 55+AA = FF, 3C+C5 = 01 -> image sums to 00h
        mem[0]      = 8'h55;
        mem[1]      = 8'hAA;
        mem[15'h123] = 8'h3C;
        mem[15'h124] = 8'hC5;

        repeat (3) @(negedge clk);
        reset_values("reset");
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        isa_read(15'h0123, 8'h3C);

        start_session();
        beat(15'h0000, 8'h55, 1'b0);
        beat(15'h0001, 8'hAA, 1'b0);
        beat(15'h0123, 8'h3C, 1'b0);
        beat(15'h0124, 8'hC5, 1'b0);
        csum_q.push_back({8'h00, 1'b1, 1'b1});
        beat(15'h0010, 8'h00, 1'b1);
        wait_done();
        isa_read(15'h0124, 8'hC5);

        start_session();
        csum_q.push_back({8'h01, 1'b0, 1'b0});
        beat(15'h0010, 8'h01, 1'b1);
        wait_done();
        isa_read(15'h0123, 8'hFF);

        start_session();
        isa_q.push_back(8'hFF);
        isa_addr = 15'h0123;
        isa_sel  = 1'b1;
        @(negedge clk);
        upd_if.upd_valid = 1'b1;
        upd_if.upd_addr  = 15'h0010;
        upd_if.upd_data  = 8'h00;
        upd_if.upd_last  = 1'b1;
        check("ready_gated_by_sel", upd_if.upd_ready, 0);
        seen = 1'b0;
        wn   = 0;
        while (!upd_if.upd_ready && wn < 60) begin
            @(negedge clk);
            wn++;
            if (isa_rdata_vld) begin
                seen    = 1'b1;
                isa_sel = 1'b0;
            end
        end
        check("isa_before_beat", seen, 1);
        check("beat_ready_after_isa", upd_if.upd_ready, 1);
        csum_q.push_back({8'h00, 1'b1, 1'b1});
        @(negedge clk);
        upd_if.upd_valid = 1'b0;
        upd_if.upd_last  = 1'b0;
        check("scan_busy", upd_busy, 1);
        repeat (200) @(negedge clk);
        isa_read(15'h0123, 8'hFF);
        wait_done();

        start_session();
        for (int i = 0; i < 500; i++)
            beat(AW'(32'h5000 + i), 8'(i), 1'b0);
        check("beat500_write", bram_we, 1);
        reset_n = 1'b0;
        #1;
        reset_values("midreset");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        isa_read(15'h0123, 8'h3C);

        repeat (5) @(negedge clk);
        check("isa_q_drained", isa_q.size(), 0);
        check("csum_q_drained", csum_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
